// File: rtl/sweep_peak_detector_pkg.sv
// Shared types and widths for the sweep peak detector: FSM encoding, default
// counter width and the most-negative sample constant used to seed the running maximum.
package sweep_peak_detector_pkg;

  localparam int word_width      = 16;
  localparam int sweep_cnt_width = 16;

  typedef enum logic [1:0] {PK_IDLE, PK_SEARCH, PK_DONE} peak_state_t;

  function automatic logic signed [word_width-1:0] most_neg();
    return {1'b1, {(word_width-1){1'b0}}};
  endfunction

endpackage

// File: rtl/sweep_peak_detector.sv
// Tracks the signed maximum (first occurrence) of a smoothed sample stream over one
// sweep and publishes value, index and a threshold-qualified found flag at sweep end.
module sweep_peak_detector
  import sweep_peak_detector_pkg::*;
#(
  parameter int cnt_width = sweep_cnt_width
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sweep_start,
  input  logic                         sweep_abort,
  input  logic        [cnt_width-1:0]  sweep_len,
  input  logic signed [word_width-1:0] threshold,
  input  logic signed [word_width-1:0] sample_in,
  input  logic                         sample_in_valid,
  output logic                         busy,
  output logic signed [word_width-1:0] peak_value,
  output logic        [cnt_width-1:0]  peak_index,
  output logic                         peak_found,
  output logic                         peak_valid
);

  peak_state_t                  state_q, state_d;
  logic        [cnt_width-1:0]  len_q, cnt_q, run_idx_q;
  logic signed [word_width-1:0] thr_q, run_max_q;

  logic                         load, accept, publish, upd;
  logic        [cnt_width-1:0]  cnt_nxt, cand_idx, pub_idx;
  logic signed [word_width-1:0] cand_max, pub_max, pub_thr;

  // Results are captured on the edge that enters DONE, so the pulse and the
  // updated registers appear together one cycle after the final sample's edge.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    accept   = 1'b0;
    publish  = 1'b0;
    cnt_nxt  = cnt_q + cnt_width'(1);
    upd      = sample_in_valid && ($signed(sample_in) > $signed(run_max_q));
    cand_max = upd ? sample_in : run_max_q;
    cand_idx = upd ? cnt_q : run_idx_q;
    pub_max  = cand_max;
    pub_idx  = cand_idx;
    pub_thr  = thr_q;

    if (sweep_abort) begin
      state_d = PK_IDLE;
    end else if (sweep_start) begin
      load = 1'b1;
      if (sweep_len == '0) begin
        state_d = PK_DONE;
        publish = 1'b1;
        pub_max = most_neg();
        pub_idx = '0;
        pub_thr = threshold;
      end else begin
        state_d = PK_SEARCH;
      end
    end else begin
      case (state_q)
        PK_SEARCH: begin
          if (sample_in_valid) begin
            accept = 1'b1;
            if (cnt_nxt == len_q) begin
              state_d = PK_DONE;
              publish = 1'b1;
            end
          end
        end
        PK_DONE: state_d = PK_IDLE;
        default: state_d = PK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PK_IDLE;
      len_q      <= '0;
      thr_q      <= '0;
      cnt_q      <= '0;
      run_max_q  <= most_neg();
      run_idx_q  <= '0;
      peak_value <= most_neg();
      peak_index <= '0;
      peak_found <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        len_q     <= sweep_len;
        thr_q     <= threshold;
        cnt_q     <= '0;
        run_max_q <= most_neg();
        run_idx_q <= '0;
      end else if (accept) begin
        cnt_q     <= cnt_nxt;
        run_max_q <= cand_max;
        run_idx_q <= cand_idx;
      end
      if (publish) begin
        peak_value <= pub_max;
        peak_index <= pub_idx;
        peak_found <= ($signed(pub_max) >= $signed(pub_thr));
      end
    end
  end

  assign busy       = (state_q == PK_SEARCH);
  assign peak_valid = (state_q == PK_DONE);

endmodule

// File: tb/tb_sweep_peak_detector.sv
// Scoreboard bench for sweep_peak_detector: directed sweeps push expected results,
// a negedge monitor pops and compares whenever peak_valid pulses.
module tb_sweep_peak_detector;
  import sweep_peak_detector_pkg::*;

  localparam int CW = sweep_cnt_width;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic                         sweep_start = 1'b0;
  logic                         sweep_abort = 1'b0;
  logic        [CW-1:0]         sweep_len = '0;
  logic signed [word_width-1:0] threshold = '0;
  logic signed [word_width-1:0] sample_in = '0;
  logic                         sample_in_valid = 1'b0;
  logic                         busy;
  logic signed [word_width-1:0] peak_value;
  logic        [CW-1:0]         peak_index;
  logic                         peak_found;
  logic                         peak_valid;

  typedef struct {
    logic signed [word_width-1:0] value;
    logic [CW-1:0]                index;
    logic                         found;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  sweep_peak_detector #(.cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .sweep_len(sweep_len), .threshold(threshold), .sample_in(sample_in),
    .sample_in_valid(sample_in_valid), .busy(busy), .peak_value(peak_value),
    .peak_index(peak_index), .peak_found(peak_found), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int v, input int idx, input bit f);
    exp_t e;
    e.value = word_width'(v);
    e.index = CW'(idx);
    e.found = f;
    exp_q.push_back(e);
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && peak_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("peak_value", longint'(peak_value), longint'(e.value));
        chk("peak_index", longint'(peak_index), longint'(e.index));
        chk("peak_found", longint'(peak_found), longint'(e.found));
      end
    end
  end

  task automatic start(input int len, input int thr);
    sweep_len   = CW'(len);
    threshold   = word_width'(thr);
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
  endtask

  task automatic smp(input int v);
    sample_in       = word_width'(v);
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      idle(1);
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_value", longint'(peak_value), -32768);
    chk("rst_index", peak_index, 0);
    chk("rst_found", peak_found, 0);
    chk("rst_valid", peak_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Basic sweep with a tie: first occurrence of 20 wins
    push(20, 2, 1'b1);
    start(5, 10);
    chk("busy_search", busy, 1);
    smp(3); smp(7); smp(20); smp(20); smp(-4);
    drain("t2_drain");
    chk("busy_after", busy, 0);

    // All-negative sweep with gaps; threshold/len changes mid-sweep are ignored
    push(-9, 1, 1'b0);
    start(4, 100);
    threshold = -100;
    sweep_len = 2;
    smp(-50); idle(2); smp(-9); idle(1); smp(-30); idle(3); smp(-9);
    drain("t3_drain");

    // Restart mid-sweep discards the first partial sweep
    push(8, 7, 1'b1);
    start(8, 0);
    smp(50); smp(60); smp(70);
    start(8, 0);
    for (int i = 1; i <= 8; i++) smp(i);
    drain("t4_drain");

    // Zero-length sweep publishes the seed value one cycle after start
    push(-32768, 0, 1'b0);
    start(0, 0);
    @(negedge clk);
    chk("len0_pulse", peak_valid, 1);
    drain("t5_drain");

    // Start during DONE: result published, then the new sweep runs
    push(5, 0, 1'b1);
    push(-3, 0, 1'b0);
    start(2, 0);
    smp(5); smp(5);
    start(1, 0);
    chk("restart_from_done", busy, 1);
    smp(-3);
    drain("t6_drain");

    // Abort mid-sweep: no pulse, previous result held
    start(6, 0);
    smp(100); smp(200);
    sweep_abort = 1'b1;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_abort = 1'b0;
    sweep_start = 1'b0;
    chk("abort_busy", busy, 0);
    smp(300); smp(400); smp(500); smp(600);
    idle(3);
    chk("abort_held_value", longint'(peak_value), -3);
    chk("abort_held_found", peak_found, 0);

    // Asynchronous reset mid-sweep after a found=1 result
    push(40, 1, 1'b1);
    start(2, 0);
    smp(10); smp(40);
    drain("t8_drain");
    start(5, 0);
    smp(1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_value", longint'(peak_value), -32768);
    chk("arst_found", peak_found, 0);
    chk("arst_valid", peak_valid, 0);
    idle(2);
    rst = 1'b1;
    smp(7); smp(8); smp(9); smp(10);
    idle(3);
    chk("arst_no_pulse", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
